// File: rtl/csr_unit.sv
// csr_unit: RV32 machine-mode CSR file with clocked writes, mcycle/minstret
// counters, trap entry / MRET sequencing, interrupt pending/enable logic and
// illegal-access detection.
// Optional feature macro: CSR_VECTORED_EN (vectored mtvec mode for interrupts).
module csr_unit #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h40000100,
    parameter logic [31:0] MTVEC_RESET = 32'h00000000,
    parameter int unsigned COUNTER_W   = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csr_en_i,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] addr_i,
    input  logic [4:0]  rs1_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        illegal_o,
    input  logic        instret_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_sw_i,
    output logic        irq_pending_o,
    output logic [31:0] irq_cause_o,
    output logic [31:0] trap_vector_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [COUNTER_W-1:0] CNT_ONE = {{(COUNTER_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic                 mstatus_mie;
    logic                 mstatus_mpie;
    logic [2:0]           mie_bits;    // {MEIE, MTIE, MSIE}
    logic [2:0]           mip_bits;    // {MEIP, MTIP, MSIP} sampled lines
    logic [31:2]          mtvec_base;
`ifdef CSR_VECTORED_EN
    logic [1:0]           mtvec_mode;
`endif
    logic [31:0]          mscratch;
    logic [31:0]          mepc;
    logic [31:0]          mcause;
    logic [31:0]          mtval;
    logic [COUNTER_W-1:0] mcycle;
    logic [COUNTER_W-1:0] minstret;

    // Decode helpers
    logic [31:0] src;
    logic [31:0] rd_val;
    logic [31:0] new_val;
    logic [31:0] mtvec_rd;
    logic [31:0] cycle_hi;
    logic [31:0] instret_hi;
    logic [31:0] vec_base;
    logic [2:0]  irq_masked;
    logic        supported;
    logic        read_only;
    logic        write_intent;
    logic        illegal;
    logic        do_write;
    logic        wr_cycle_lo;
    logic        wr_cycle_hi;
    logic        wr_instret_lo;
    logic        wr_instret_hi;

    // Upper counter halves, zero-extended above COUNTER_W-1
    always_comb begin
        cycle_hi   = '0;
        instret_hi = '0;
        cycle_hi[COUNTER_W-33:0]   = mcycle[COUNTER_W-1:32];
        instret_hi[COUNTER_W-33:0] = minstret[COUNTER_W-1:32];
    end

`ifdef CSR_VECTORED_EN
    assign mtvec_rd = {mtvec_base, mtvec_mode};
`else
    assign mtvec_rd = {mtvec_base, 2'b00};
`endif

    // Address decode and old-value read mux
    always_comb begin
        supported = 1'b1;
        rd_val    = '0;
        case (addr_i)
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: rd_val = '0;
            ADDR_MHARTID:   rd_val = HART_ID;
            ADDR_MISA:      rd_val = MISA_VALUE;
            ADDR_MSTATUS:   rd_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            ADDR_MIE:       rd_val = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0};
            ADDR_MTVEC:     rd_val = mtvec_rd;
            ADDR_MSCRATCH:  rd_val = mscratch;
            ADDR_MEPC:      rd_val = mepc;
            ADDR_MCAUSE:    rd_val = mcause;
            ADDR_MTVAL:     rd_val = mtval;
            ADDR_MIP:       rd_val = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};
            ADDR_MCYCLE:    rd_val = mcycle[31:0];
            ADDR_MCYCLEH:   rd_val = cycle_hi;
            ADDR_MINSTRET:  rd_val = minstret[31:0];
            ADDR_MINSTRETH: rd_val = instret_hi;
            default:        supported = 1'b0;
        endcase
    end

    // Operand selection, write intent, legality and write-back value
    always_comb begin
        src          = funct3_i[2] ? {27'b0, rs1_i} : wdata_i;
        write_intent = (funct3_i[1:0] == 2'b01) ||
                       ((funct3_i[1:0] != 2'b00) && (rs1_i != 5'd0));
        read_only    = (addr_i[11:10] == 2'b11) || (addr_i == ADDR_MISA) || (addr_i == ADDR_MIP);
        illegal      = csr_en_i && (!supported || (write_intent && read_only));
        case (funct3_i[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = rd_val | src;
            2'b11:   new_val = rd_val & ~src;
            default: new_val = rd_val;
        endcase
        do_write      = csr_en_i && write_intent && !illegal && !trap_i && !mret_i;
        wr_cycle_lo   = do_write && (addr_i == ADDR_MCYCLE);
        wr_cycle_hi   = do_write && (addr_i == ADDR_MCYCLEH);
        wr_instret_lo = do_write && (addr_i == ADDR_MINSTRET);
        wr_instret_hi = do_write && (addr_i == ADDR_MINSTRETH);
    end

    assign illegal_o = illegal;
    assign rdata_o   = (csr_en_i && !illegal) ? rd_val : '0;

    // Interrupt pending and priority encode: ext > sw > timer
    always_comb begin
        irq_masked    = mip_bits & mie_bits;
        irq_pending_o = mstatus_mie && (irq_masked != 3'b000);
        irq_cause_o   = '0;
        if (irq_pending_o) begin
            if (irq_masked[2])      irq_cause_o = {1'b1, 27'b0, 4'd11};
            else if (irq_masked[0]) irq_cause_o = {1'b1, 27'b0, 4'd3};
            else                    irq_cause_o = {1'b1, 27'b0, 4'd7};
        end
    end

    // Next fetch PC for trap entry or MRET
    always_comb begin
        vec_base      = {mtvec_base, 2'b00};
        trap_vector_o = vec_base;
`ifdef CSR_VECTORED_EN
        if (mtvec_mode[0] && trap_cause_i[31])
            trap_vector_o = vec_base + {25'b0, trap_cause_i[4:0], 2'b00};
`endif
        if (mret_i)
            trap_vector_o = mepc;
    end

    // Trap/MRET/CSR-write state updates, trap > mret > write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_bits     <= '0;
            mtvec_base   <= MTVEC_RESET[31:2];
`ifdef CSR_VECTORED_EN
            mtvec_mode   <= '0;
`endif
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else if (trap_i) begin
            mepc         <= {trap_pc_i[31:2], 2'b00};
            mcause       <= trap_cause_i;
            mtval        <= trap_tval_i;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (do_write) begin
            case (addr_i)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= new_val[3];
                    mstatus_mpie <= new_val[7];
                end
                ADDR_MIE:      mie_bits <= {new_val[11], new_val[7], new_val[3]};
                ADDR_MTVEC: begin
                    mtvec_base <= new_val[31:2];
`ifdef CSR_VECTORED_EN
                    // WARL: reserved modes 2'b1x collapse to direct mode
                    mtvec_mode <= new_val[1] ? 2'b00 : new_val[1:0];
`endif
                end
                ADDR_MSCRATCH: mscratch <= new_val;
                ADDR_MEPC:     mepc     <= {new_val[31:2], 2'b00};
                ADDR_MCAUSE:   mcause   <= new_val;
                ADDR_MTVAL:    mtval    <= new_val;
                default: ;
            endcase
        end
    end

    // Counters: a write to either half replaces it and skips that cycle's increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_cycle_lo)
                mcycle[31:0] <= new_val;
            else if (wr_cycle_hi)
                mcycle[COUNTER_W-1:32] <= new_val[COUNTER_W-33:0];
            else
                mcycle <= mcycle + CNT_ONE;

            if (wr_instret_lo)
                minstret[31:0] <= new_val;
            else if (wr_instret_hi)
                minstret[COUNTER_W-1:32] <= new_val[COUNTER_W-33:0];
            else if (instret_i)
                minstret <= minstret + CNT_ONE;
        end
    end

    // Interrupt lines sampled once into mip
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mip_bits <= '0;
        else         mip_bits <= {irq_ext_i, irq_timer_i, irq_sw_i};
    end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: scoreboard bench for csr_unit against a word-level CSR model.
module tb_csr_unit;

    localparam int unsigned CW    = 40;
    localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;
    localparam logic [31:0] HART  = 32'd5;
    localparam logic [31:0] MISA  = 32'h40000100;
    localparam logic [31:0] TVEC0 = 32'h100;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        csr_en_i;
    logic [2:0]  funct3_i;
    logic [11:0] addr_i;
    logic [4:0]  rs1_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        illegal_o;
    logic        instret_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_tval_i;
    logic        mret_i;
    logic        irq_ext_i, irq_timer_i, irq_sw_i;
    logic        irq_pending_o;
    logic [31:0] irq_cause_o;
    logic [31:0] trap_vector_o;

    csr_unit #(
        .HART_ID(HART), .MISA_VALUE(MISA), .MTVEC_RESET(TVEC0), .COUNTER_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .csr_en_i(csr_en_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .rs1_i(rs1_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .illegal_o(illegal_o), .instret_i(instret_i), .trap_i(trap_i),
        .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
        .mret_i(mret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
        .irq_sw_i(irq_sw_i), .irq_pending_o(irq_pending_o), .irq_cause_o(irq_cause_o),
        .trap_vector_o(trap_vector_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] wdata;
        logic        instret, trap, mret, ext, tim, sw;
        logic [31:0] cause, pc, tval;
    } stim_t;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        pend;
        logic [31:0] icause;
        logic [31:0] tvec;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    // Reference model: architectural CSR values as whole words
    logic        m_mie, m_mpie;
    logic [31:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cyc, m_ins;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0; m_tvec = TVEC0;
        m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic bit ref_read(input logic [11:0] a, output logic [31:0] v);
        v = 0;
        case (a)
            12'hF11, 12'hF12, 12'hF13: v = 0;
            12'hF14: v = HART;
            12'h301: v = MISA;
            12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h304: v = m_ie;
            12'h305: v = m_tvec;
            12'h340: v = m_scratch;
            12'h341: v = m_epc;
            12'h342: v = m_cause;
            12'h343: v = m_tval;
            12'h344: v = m_ip;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            default: return 0;
        endcase
        return 1;
    endfunction

    function automatic bit wants_write(input stim_t s);
        return (s.f3[1:0] == 2'b01) || (s.f3[1:0] != 2'b00 && s.rs1 != 0);
    endfunction

    function automatic bit is_illegal(input stim_t s, input bit known);
        bit ro;
        ro = (s.addr[11:10] == 2'b11) || (s.addr == 12'h301) || (s.addr == 12'h344);
        return s.en && (!known || (wants_write(s) && ro));
    endfunction

    function automatic exp_t ref_eval(input stim_t s);
        exp_t e;
        logic [31:0] old, act;
        bit known;
        known     = ref_read(s.addr, old);
        e.illegal = is_illegal(s, known);
        e.rdata   = (s.en && !e.illegal) ? old : 32'h0;
        act       = m_ip & m_ie;
        e.pend    = m_mie && (act != 0);
        if (!e.pend)        e.icause = 0;
        else if (act[11])   e.icause = 32'h8000000B;
        else if (act[3])    e.icause = 32'h80000003;
        else                e.icause = 32'h80000007;
        e.tvec = m_tvec & ~32'h3;
`ifdef CSR_VECTORED_EN
        if (m_tvec[0] && s.cause[31]) e.tvec = e.tvec + 4 * s.cause[4:0];
`endif
        if (s.mret) e.tvec = m_epc;
        return e;
    endfunction

    function automatic void ref_step(input stim_t s);
        logic [31:0] old, src, nv;
        logic [63:0] ncyc, nins;
        bit known, w;
        known = ref_read(s.addr, old);
        src   = s.f3[2] ? {27'b0, s.rs1} : s.wdata;
        case (s.f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
        w    = s.en && wants_write(s) && !is_illegal(s, known) && !s.trap && !s.mret;
        ncyc = (m_cyc + 1) & CMASK;
        nins = (m_ins + 64'(s.instret)) & CMASK;
        if (w) begin
            case (s.addr)
                12'hB00: ncyc = {m_cyc[63:32], nv};
                12'hB80: ncyc = {nv, m_cyc[31:0]} & CMASK;
                12'hB02: nins = {m_ins[63:32], nv};
                12'hB82: nins = {nv, m_ins[31:0]} & CMASK;
                default: ;
            endcase
        end
        if (s.trap) begin
            m_epc = s.pc & ~32'h3; m_cause = s.cause; m_tval = s.tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (s.mret) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (w) begin
            case (s.addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_ie = nv & 32'h888;
`ifdef CSR_VECTORED_EN
                12'h305: m_tvec = nv[1] ? (nv & ~32'h3) : nv;
`else
                12'h305: m_tvec = nv & ~32'h3;
`endif
                12'h340: m_scratch = nv;
                12'h341: m_epc = nv & ~32'h3;
                12'h342: m_cause = nv;
                12'h343: m_tval = nv;
                default: ;
            endcase
        end
        m_ip  = (32'(s.ext) << 11) | (32'(s.tim) << 7) | (32'(s.sw) << 3);
        m_cyc = ncyc;
        m_ins = nins;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.en = 0; s.f3 = 0; s.addr = 0; s.rs1 = 0; s.wdata = 0;
        s.instret = 0; s.trap = 0; s.mret = 0; s.ext = 0; s.tim = 0; s.sw = 0;
        s.cause = 0; s.pc = 0; s.tval = 0;
        return s;
    endfunction

    function automatic stim_t csr(input logic [2:0] f3, input logic [11:0] a,
                                  input logic [4:0] rs1, input logic [31:0] wd);
        stim_t s;
        s = idle();
        s.en = 1; s.f3 = f3; s.addr = a; s.rs1 = rs1; s.wdata = wd;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        csr_en_i = s.en; funct3_i = s.f3; addr_i = s.addr; rs1_i = s.rs1; wdata_i = s.wdata;
        instret_i = s.instret; trap_i = s.trap; mret_i = s.mret;
        trap_cause_i = s.cause; trap_pc_i = s.pc; trap_tval_i = s.tval;
        irq_ext_i = s.ext; irq_timer_i = s.tim; irq_sw_i = s.sw;
    endtask

    // Drive one cycle: push expectation, advance model, wait for the edge
    task automatic cycle(input stim_t s);
        apply(s);
        sb.push_back(ref_eval(s));
        ref_step(s);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against queued expectations mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni && sb.size() > 0) begin
                e = sb.pop_front();
                check("rdata",   rdata_o,             e.rdata);
                check("illegal", 32'(illegal_o),      32'(e.illegal));
                check("pending", 32'(irq_pending_o),  32'(e.pend));
                check("irqcause", irq_cause_o,        e.icause);
                check("tvector", trap_vector_o,       e.tvec);
            end
        end
    end

    logic [11:0] alist [0:19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hF11, 12'hF14, 12'h7C0, 12'h345, 12'hB01,
                                  12'h340, 12'h304};

    initial begin
        stim_t s;
        rst_ni = 0;
        apply(idle());
        model_reset();
        #12;
        check("rst_rdata",   rdata_o,               32'h0);
        check("rst_illegal", 32'(illegal_o),        32'h0);
        check("rst_pending", 32'(irq_pending_o),    32'h0);
        check("rst_cause",   irq_cause_o,           32'h0);
        check("rst_tvector", trap_vector_o,         TVEC0);
        @(posedge clk);
        #1;
        rst_ni = 1;

        // Reset values and free-running mcycle
        cycle(csr(3'b010, 12'h305, 5'd0, 32'h0));
        cycle(csr(3'b010, 12'h300, 5'd0, 32'h0));
        cycle(csr(3'b010, 12'hB00, 5'd0, 32'h0));
        repeat (10) cycle(idle());
        cycle(csr(3'b010, 12'hB00, 5'd0, 32'h0));

        // mscratch RW / RS-with-x0 / RCI
        cycle(csr(3'b001, 12'h340, 5'd3, 32'hDEADBEEF));
        cycle(csr(3'b010, 12'h340, 5'd0, 32'h12345678));
        cycle(csr(3'b111, 12'h340, 5'h0F, 32'h0));
        cycle(csr(3'b010, 12'h340, 5'd0, 32'h0));

        // Counter carry into the high half and upper-bit truncation
        cycle(csr(3'b001, 12'hB00, 5'd1, 32'hFFFFFFFF));
        cycle(csr(3'b001, 12'hB80, 5'd1, 32'h0));
        cycle(idle());
        cycle(idle());
        cycle(csr(3'b010, 12'hB80, 5'd0, 32'h0));
        cycle(csr(3'b010, 12'hB00, 5'd0, 32'h0));
        cycle(csr(3'b001, 12'hB80, 5'd1, 32'hFFFFFFFF));
        cycle(csr(3'b010, 12'hB80, 5'd0, 32'h0));

        // External interrupt pending with one-cycle sampling latency
        cycle(csr(3'b001, 12'h304, 5'd1, 32'h800));
        cycle(csr(3'b110, 12'h300, 5'd8, 32'h0));
        s = idle(); s.ext = 1;
        repeat (3) cycle(s);

        // Trap entry then MRET
        s = idle(); s.trap = 1; s.cause = 32'd2; s.pc = 32'h1236; s.tval = 32'h13;
        cycle(s);
        cycle(csr(3'b010, 12'h341, 5'd0, 32'h0));
        cycle(csr(3'b010, 12'h342, 5'd0, 32'h0));
        cycle(csr(3'b010, 12'h343, 5'd0, 32'h0));
        cycle(csr(3'b010, 12'h300, 5'd0, 32'h0));
        s = idle(); s.mret = 1;
        cycle(s);
        cycle(csr(3'b010, 12'h300, 5'd0, 32'h0));

        // Illegal accesses leave state untouched
        cycle(csr(3'b001, 12'hF11, 5'd1, 32'hFFFFFFFF));
        cycle(csr(3'b010, 12'h7C0, 5'd0, 32'h0));
        cycle(csr(3'b001, 12'h301, 5'd1, 32'h0));
        cycle(csr(3'b010, 12'h301, 5'd0, 32'h0));

        // Randomized mixture
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.en      = ($urandom_range(0, 9) < 7);
            s.f3      = 3'($urandom_range(0, 7));
            s.addr    = alist[$urandom_range(0, 19)];
            s.rs1     = ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom);
            s.wdata   = $urandom;
            s.instret = 1'($urandom);
            s.trap    = ($urandom_range(0, 19) == 0);
            s.mret    = ($urandom_range(0, 19) == 0);
            s.cause   = {1'($urandom), 26'b0, 5'($urandom)};
            s.pc      = $urandom;
            s.tval    = $urandom;
            s.ext     = ($urandom_range(0, 3) == 0);
            s.tim     = ($urandom_range(0, 3) == 0);
            s.sw      = ($urandom_range(0, 3) == 0);
            cycle(s);
        end

        apply(idle());
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'h0);

        // Asynchronous reset clears state without waiting for an edge
        @(posedge clk);
        #2;
        ref_step(idle());
        apply(csr(3'b010, 12'hB00, 5'd0, 32'h0));
        #1;
        check("pre_rst_mcycle", rdata_o, m_cyc[31:0]);
        rst_ni = 0;
        #1;
        check("async_mcycle", rdata_o,       32'h0);
        check("async_tvector", trap_vector_o, TVEC0);
        check("async_pending", 32'(irq_pending_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
